// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 host transmitter shared types, commands and timing defaults
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_DATA      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5,
    ST_FAIL      = 3'd6
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;

  localparam int DEF_INHIBIT_CYCLES       = 6000;
  localparam int DEF_START_TIMEOUT_CYCLES = 750000;
  localparam int DEF_XFER_TIMEOUT_CYCLES  = 100000;
  localparam int DEF_CNT_W                = 20;

  localparam logic [1:0] RETRY_MAX = 2'd2;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command byte request/response bundle for the PS/2 host transmitter
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;

  modport master (output tx_data, output tx_valid,
                  input  tx_ready, input tx_done, input tx_error);
  modport slave  (input  tx_data, input tx_valid,
                  output tx_ready, output tx_done, output tx_error);
endinterface

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - PS/2 pin synchronizer with clock falling-edge detect
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_pin,
  input  logic dat_pin,
  output logic clk_s,
  output logic dat_s,
  output logic clk_fe
);

  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_prev;

  // Idle bus level is high, so resetting to 1 avoids a false edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], clk_pin};
      dat_sync <= {dat_sync[0], dat_pin};
      clk_prev <= clk_sync[1];
    end
  end

  assign clk_s  = clk_sync[1];
  assign dat_s  = dat_sync[1];
  assign clk_fe = clk_prev & ~clk_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter; PS2_TX_RETRY_EN enables retries
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES       = DEF_INHIBIT_CYCLES,
  parameter int START_TIMEOUT_CYCLES = DEF_START_TIMEOUT_CYCLES,
  parameter int XFER_TIMEOUT_CYCLES  = DEF_XFER_TIMEOUT_CYCLES,
  parameter int CNT_W                = DEF_CNT_W
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  ps2_host_tx_if.slave     tx,
  output logic             rx_inhibit,
  input  logic             ps2_clk_in,
  input  logic             ps2_dat_in,
  output logic             ps2_clk_drive_low,
  output logic             ps2_dat_drive_low
);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT_CYCLES - 1);

  ps2_tx_state_e    state, state_n;
  logic [CNT_W-1:0] timer, timer_n, timer_inc;
  logic [8:0]       shift, shift_n;
  logic [3:0]       bitcnt, bitcnt_n;
  logic             dat_low, dat_low_n;
  logic             ack, ack_n;
  logic             done, err;
  logic             clk_s, dat_s, clk_fe;
  logic             xfer_expired;

`ifdef PS2_TX_RETRY_EN
  logic [1:0]       retry_cnt, retry_cnt_n;
  logic [8:0]       frame_q, frame_n;
  logic             retryable, retryable_n;
`endif

  ps2_line_sync u_sync (
    .clk     (CLOCK_50),
    .rst_n   (resetn),
    .clk_pin (ps2_clk_in),
    .dat_pin (ps2_dat_in),
    .clk_s   (clk_s),
    .dat_s   (dat_s),
    .clk_fe  (clk_fe)
  );

  assign timer_inc    = (timer == {CNT_W{1'b1}}) ? timer : timer + 1'b1;
  assign xfer_expired = (timer >= XFER_LAST);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      timer     <= '0;
      shift     <= '0;
      bitcnt    <= '0;
      dat_low   <= 1'b0;
      ack       <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt <= '0;
      frame_q   <= '0;
      retryable <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      shift     <= shift_n;
      bitcnt    <= bitcnt_n;
      dat_low   <= dat_low_n;
      ack       <= ack_n;
`ifdef PS2_TX_RETRY_EN
      retry_cnt <= retry_cnt_n;
      frame_q   <= frame_n;
      retryable <= retryable_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    timer_n     = timer_inc;
    shift_n     = shift;
    bitcnt_n    = bitcnt;
    dat_low_n   = dat_low;
    ack_n       = ack;
    done        = 1'b0;
    err         = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_cnt_n = retry_cnt;
    frame_n     = frame_q;
    retryable_n = retryable;
`endif
    case (state)
      ST_IDLE: begin
        timer_n   = '0;
        dat_low_n = 1'b0;
        if (tx.tx_valid) begin
          shift_n = {odd_parity(tx.tx_data), tx.tx_data};
          ack_n   = 1'b0;
          state_n = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          frame_n     = {odd_parity(tx.tx_data), tx.tx_data};
          retry_cnt_n = '0;
`endif
        end
      end
      ST_INHIBIT: begin
        if (timer >= INH_LAST) begin
          state_n   = ST_REQ;
          timer_n   = '0;
          dat_low_n = 1'b1;
        end
      end
      ST_REQ: begin
        // The request edge already clocks out data bit 0.
        if (clk_fe) begin
          state_n   = ST_DATA;
          timer_n   = '0;
          bitcnt_n  = '0;
          dat_low_n = ~shift[0];
          shift_n   = {1'b0, shift[8:1]};
        end else if (timer >= START_LAST) begin
          state_n = ST_FAIL;
`ifdef PS2_TX_RETRY_EN
          retryable_n = 1'b0;
`endif
        end
      end
      ST_DATA: begin
        if (xfer_expired) begin
          state_n = ST_FAIL;
`ifdef PS2_TX_RETRY_EN
          retryable_n = 1'b1;
`endif
        end else if (clk_fe) begin
          if (bitcnt == 4'd8) begin
            dat_low_n = 1'b0;
            state_n   = ST_ACK;
          end else begin
            dat_low_n = ~shift[0];
            shift_n   = {1'b0, shift[8:1]};
            bitcnt_n  = bitcnt + 4'd1;
          end
        end
      end
      ST_ACK: begin
        if (xfer_expired) begin
          state_n = ST_FAIL;
`ifdef PS2_TX_RETRY_EN
          retryable_n = 1'b1;
`endif
        end else if (clk_fe) begin
          ack_n   = ~dat_s;
          state_n = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        // A missing ACK is only reported once the device has let the bus go idle.
        if (xfer_expired || (clk_s && dat_s && !ack)) begin
          state_n = ST_FAIL;
`ifdef PS2_TX_RETRY_EN
          retryable_n = 1'b1;
`endif
        end else if (clk_s && dat_s) begin
          done    = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_FAIL: begin
`ifdef PS2_TX_RETRY_EN
        if (retryable && (retry_cnt != RETRY_MAX)) begin
          retry_cnt_n = retry_cnt + 2'd1;
          shift_n     = frame_q;
          ack_n       = 1'b0;
          timer_n     = '0;
          state_n     = ST_INHIBIT;
        end else begin
          err     = 1'b1;
          state_n = ST_IDLE;
        end
`else
        err     = 1'b1;
        state_n = ST_IDLE;
`endif
      end
      default: state_n = ST_IDLE;
    endcase
    if (state_n == ST_FAIL) dat_low_n = 1'b0;
  end

  assign tx.tx_ready        = (state == ST_IDLE);
  assign tx.tx_done         = done;
  assign tx.tx_error        = err;
  assign rx_inhibit         = (state != ST_IDLE);
  assign ps2_clk_drive_low  = (state == ST_INHIBIT);
  assign ps2_dat_drive_low  = dat_low;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  logic rx_inhibit, ps2_clk_drive_low, ps2_dat_drive_low;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic clk_line, dat_line;

  int n_cmp = 0;
  int n_bad = 0;
  int done_tot = 0;
  int err_tot = 0;
  int both_tot = 0;
  int inh_bad = 0;

  ps2_host_tx_if txi ();

  assign clk_line = ~(dev_clk_low | ps2_clk_drive_low);
  assign dat_line = ~(dev_dat_low | ps2_dat_drive_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES       (20),
    .START_TIMEOUT_CYCLES (400),
    .XFER_TIMEOUT_CYCLES  (2000),
    .CNT_W                (20)
  ) dut (
    .CLOCK_50          (CLOCK_50),
    .resetn            (resetn),
    .tx                (txi.slave),
    .rx_inhibit        (rx_inhibit),
    .ps2_clk_in        (clk_line),
    .ps2_dat_in        (dat_line),
    .ps2_clk_drive_low (ps2_clk_drive_low),
    .ps2_dat_drive_low (ps2_dat_drive_low)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (txi.tx_done) done_tot++;
    if (txi.tx_error) err_tot++;
    if (txi.tx_done && txi.tx_error) both_tot++;
    if ((ps2_clk_drive_low || ps2_dat_drive_low) && !rx_inhibit) inh_bad++;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit hold);
    @(negedge CLOCK_50);
    txi.tx_data  = d;
    txi.tx_valid = 1'b1;
    @(negedge CLOCK_50);
    if (!hold) txi.tx_valid = 1'b0;
  endtask

  task automatic measure_inhibit(output int len);
    int guard;
    guard = 0;
    len   = 0;
    while (!ps2_clk_drive_low && guard < 500) begin
      @(negedge CLOCK_50);
      guard++;
    end
    while (ps2_clk_drive_low && len < 500) begin
      len++;
      @(negedge CLOCK_50);
    end
  endtask

  // Device model: 40-cycle clock period, samples the line just before each rising edge.
  task automatic dev_frame(input bit do_ack, output logic [10:0] bits);
    repeat (10) @(negedge CLOCK_50);
    for (int i = 0; i < 11; i++) begin
      dev_clk_low = 1'b1;
      repeat (20) @(negedge CLOCK_50);
      bits[i]     = dat_line;
      dev_clk_low = 1'b0;
      if (i == 9 && do_ack) dev_dat_low = 1'b1;
      if (i == 10) dev_dat_low = 1'b0;
      repeat (20) @(negedge CLOCK_50);
    end
  endtask

  initial begin
    logic [10:0] bits;
    logic [10:0] exp_bits;
    int len, k, d0, e0;

    txi.tx_data  = 8'h00;
    txi.tx_valid = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_ready",   {31'd0, txi.tx_ready}, 32'd1);
    check("rst_done",    {31'd0, txi.tx_done}, 32'd0);
    check("rst_error",   {31'd0, txi.tx_error}, 32'd0);
    check("rst_inhibit", {31'd0, rx_inhibit}, 32'd0);
    check("rst_clk_drv", {31'd0, ps2_clk_drive_low}, 32'd0);
    check("rst_dat_drv", {31'd0, ps2_dat_drive_low}, 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50);

    // 1: 0xED with ACK; frame {ack=0, stop=1, parity=1, 8'hED}
    d0 = done_tot; e0 = err_tot;
    send(8'hED, 1'b0);
    check("t1_ready_low", {31'd0, txi.tx_ready}, 32'd0);
    measure_inhibit(len);
    check("t1_inhibit_len", len, 32'd20);
    check("t1_start_bit", {31'd0, ps2_dat_drive_low}, 32'd1);
    check("t1_rx_inhibit", {31'd0, rx_inhibit}, 32'd1);
    dev_frame(1'b1, bits);
    check("t1_bits", {21'd0, bits}, {21'd0, 11'b01_1_11101101});
    check("t1_done", done_tot - d0, 32'd1);
    check("t1_error", err_tot - e0, 32'd0);
    check("t1_ready_after", {31'd0, txi.tx_ready}, 32'd1);

    // 2: 0x00 -> parity bit 1
    d0 = done_tot; e0 = err_tot;
    send(8'h00, 1'b0);
    measure_inhibit(len);
    dev_frame(1'b1, bits);
    check("t2_bits", {21'd0, bits}, {21'd0, 11'b01_1_00000000});
    check("t2_done", done_tot - d0, 32'd1);
    check("t2_error", err_tot - e0, 32'd0);

    // 3: device never clocks -> error 400 cycles after entering REQ, no retry
    d0 = done_tot; e0 = err_tot;
    send(8'hF3, 1'b0);
    measure_inhibit(len);
    k = 0;
    while (!txi.tx_error && k < 1000) begin
      @(negedge CLOCK_50);
      k++;
    end
    check("t3_timeout_cycles", k, 32'd400);
    check("t3_clk_released", {31'd0, ps2_clk_drive_low}, 32'd0);
    check("t3_dat_released", {31'd0, ps2_dat_drive_low}, 32'd0);
    repeat (50) @(negedge CLOCK_50);
    check("t3_error_once", err_tot - e0, 32'd1);
    check("t3_no_retry_ready", {31'd0, txi.tx_ready}, 32'd1);
    check("t3_no_done", done_tot - d0, 32'd0);

    // 4: device leaves data high at the ACK edge
    d0 = done_tot; e0 = err_tot;
    send(8'hED, 1'b0);
`ifdef PS2_TX_RETRY_EN
    for (int a = 0; a < 3; a++) begin
      measure_inhibit(len);
      check("t4_attempt_inhibit", {31'd0, len > 0}, 32'd1);
      if (a < 2) check("t4_no_early_error", err_tot - e0, 32'd0);
      dev_frame(1'b0, bits);
    end
    repeat (10) @(negedge CLOCK_50);
    check("t4_error_once", err_tot - e0, 32'd1);
    check("t4_no_done", done_tot - d0, 32'd0);
    d0 = done_tot; e0 = err_tot;
    send(8'hED, 1'b0);
    measure_inhibit(len);
    dev_frame(1'b0, bits);
    measure_inhibit(len);
    dev_frame(1'b1, bits);
    check("t4_retry_bits", {21'd0, bits}, {21'd0, 11'b01_1_11101101});
    check("t4_retry_done", done_tot - d0, 32'd1);
    check("t4_retry_error", err_tot - e0, 32'd0);
`else
    measure_inhibit(len);
    dev_frame(1'b0, bits);
    repeat (5) @(negedge CLOCK_50);
    check("t4_nack_level", {31'd0, bits[10]}, 32'd1);
    check("t4_error_once", err_tot - e0, 32'd1);
    check("t4_no_done", done_tot - d0, 32'd0);
    check("t4_ready", {31'd0, txi.tx_ready}, 32'd1);
`endif

    // 5: 0xFF held on tx_valid during a 0xED transfer
    d0 = done_tot; e0 = err_tot;
    send(8'hED, 1'b1);
    txi.tx_data = 8'hFF;
    measure_inhibit(len);
    dev_frame(1'b1, bits);
    txi.tx_valid = 1'b0;
    check("t5_first_bits", {21'd0, bits}, {21'd0, 11'b01_1_11101101});
    check("t5_second_busy", {31'd0, rx_inhibit}, 32'd1);
    measure_inhibit(len);
    dev_frame(1'b1, bits);
    exp_bits = {2'b01, 1'b1, 8'hFF};
    check("t5_second_bits", {21'd0, bits}, {21'd0, exp_bits});
    check("t5_done", done_tot - d0, 32'd2);
    check("t5_error", err_tot - e0, 32'd0);

    // 6: reset asserted while the device holds clock low for edge 5 (data bit 4 of 0xED = 0)
    d0 = done_tot; e0 = err_tot;
    send(8'hED, 1'b0);
    measure_inhibit(len);
    repeat (10) @(negedge CLOCK_50);
    for (int i = 0; i < 4; i++) begin
      dev_clk_low = 1'b1;
      repeat (20) @(negedge CLOCK_50);
      dev_clk_low = 1'b0;
      repeat (20) @(negedge CLOCK_50);
    end
    dev_clk_low = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    check("t6_bit4_driven", {31'd0, ps2_dat_drive_low}, 32'd1);
    resetn = 1'b0;
    #1;
    check("t6_clk_released", {31'd0, ps2_clk_drive_low}, 32'd0);
    check("t6_dat_released", {31'd0, ps2_dat_drive_low}, 32'd0);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    check("t6_ready", {31'd0, txi.tx_ready}, 32'd1);
    check("t6_no_done", done_tot - d0, 32'd0);
    check("t6_no_error", err_tot - e0, 32'd0);

    check("never_done_and_error", both_tot, 32'd0);
    check("rx_inhibit_while_driving", inh_bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
